// File: rtl/ssg_to_bcd_capture.sv
// rtl/ssg_to_bcd_capture.sv - seven-segment bus to BCD frame capture
//
// Watches a multiplexed seven-segment display bus and waits until each
// digit's pattern has been stable long enough. It then decodes that pattern
// back to BCD and assembles a frame of N_DIGITS digits. The finished frame is
// handed downstream over a valid/ready handshake.
//
// Optional build macro: SSG_ACTIVE_LOW_EN inverts ssg and dig_sel ahead of
// the input register, for common-anode displays. Nothing after the input
// register changes.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   ssg[6:0]     segment lines, bit6=a .. bit0=g
//   dig_sel      one-hot digit enables, bit i = digit i
//   frame_bcd    decoded frame, digit i at [4i+3:4i]
//   frame_err    bit i set = digit i was not a legal 0-9 pattern
//   frame_valid  frame_bcd/frame_err hold a complete frame
//   frame_ready  downstream accepts the frame when frame_valid is high
//   overrun      sticky, set when a completed frame was dropped
module ssg_to_bcd_capture #(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            ssg,
  input  logic [N_DIGITS-1:0]   dig_sel,
  output logic [4*N_DIGITS-1:0] frame_bcd,
  output logic [N_DIGITS-1:0]   frame_err,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  overrun
);

  localparam int RW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {WAIT, SETTLE, CAPTURED} state_t;

  logic [6:0]            in_ssg;
  logic [N_DIGITS-1:0]   in_sel;
  logic [6:0]            s_ssg, p_ssg;
  logic [N_DIGITS-1:0]   s_sel, p_sel;
  logic [RW-1:0]         run;
  logic [RW-1:0]         run_inc;
  state_t                state;
  logic [N_DIGITS-1:0]   seen;
  logic [4*N_DIGITS-1:0] slot_bcd;
  logic [N_DIGITS-1:0]   slot_err;
  logic                  changed;
  logic                  sel_onehot;
  logic                  capture;
  logic                  seen_full;
  logic                  load;
  logic [3:0]            dec_bcd;
  logic                  dec_err;

`ifdef SSG_ACTIVE_LOW_EN
  assign in_ssg = ~ssg;
  assign in_sel = ~dig_sel;
`else
  assign in_ssg = ssg;
  assign in_sel = dig_sel;
`endif

  // p_* is the previous cycle's registered sample, used to detect changes
  assign changed    = {s_sel, s_ssg} != {p_sel, p_ssg};
  assign sel_onehot = $onehot(s_sel);
  assign run_inc    = (run == RW'(STABLE_CYCLES)) ? run : run + RW'(1);
  // SETTLE always holds a one-hot select, so s_sel addresses the slot
  assign capture    = (state == SETTLE) && !changed && (run_inc == RW'(STABLE_CYCLES));
  assign seen_full  = &seen;
  assign load       = seen_full && (!frame_valid || frame_ready);

  always_comb begin
    dec_bcd = 4'hF;
    dec_err = 1'b0;
    case (s_ssg)
      7'b1111110: dec_bcd = 4'd0;
      7'b0110000: dec_bcd = 4'd1;
      7'b1101101: dec_bcd = 4'd2;
      7'b1111001: dec_bcd = 4'd3;
      7'b0110011: dec_bcd = 4'd4;
      7'b1011011: dec_bcd = 4'd5;
      7'b1011111: dec_bcd = 4'd6;
      7'b1110000: dec_bcd = 4'd7;
      7'b1111111: dec_bcd = 4'd8;
      7'b1111011: dec_bcd = 4'd9;
      default:    dec_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_ssg       <= '0;
      s_sel       <= '0;
      p_ssg       <= '0;
      p_sel       <= '0;
      run         <= '0;
      state       <= WAIT;
      seen        <= '0;
      slot_bcd    <= '0;
      slot_err    <= '0;
      frame_bcd   <= '0;
      frame_err   <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      s_ssg <= in_ssg;
      s_sel <= in_sel;
      p_ssg <= s_ssg;
      p_sel <= s_sel;

      case (state)
        WAIT: begin
          if (sel_onehot) begin
            run   <= RW'(1);
            state <= SETTLE;
          end else begin
            run <= '0;
          end
        end
        SETTLE: begin
          if (changed) begin
            if (sel_onehot) begin
              run <= RW'(1);
            end else begin
              run   <= '0;
              state <= WAIT;
            end
          end else begin
            run <= run_inc;
            if (capture) state <= CAPTURED;
          end
        end
        CAPTURED: begin
          // One capture per dwell: wait here until the bus moves on
          if (changed) begin
            if (sel_onehot) begin
              run   <= RW'(1);
              state <= SETTLE;
            end else begin
              run   <= '0;
              state <= WAIT;
            end
          end
        end
        default: begin
          run   <= '0;
          state <= WAIT;
        end
      endcase

      for (int i = 0; i < N_DIGITS; i++) begin
        if (capture && s_sel[i]) begin
          slot_bcd[4*i +: 4] <= dec_bcd;
          slot_err[i]        <= dec_err;
        end
      end

      // A full mask is consumed on the following edge, whether it is
      // delivered or dropped
      seen <= (seen_full ? '0 : seen) | (capture ? s_sel : '0);

      if (seen_full) begin
        if (load) begin
          frame_bcd   <= slot_bcd;
          frame_err   <= slot_err;
          frame_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ssg_to_bcd_capture.sv
// tb/tb_ssg_to_bcd_capture.sv - self-checking bench for ssg_to_bcd_capture
module tb_ssg_to_bcd_capture;

  localparam int N = 4;
  localparam int S = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [6:0]     ssg;
  logic [N-1:0]   dig_sel;
  logic [4*N-1:0] frame_bcd;
  logic [N-1:0]   frame_err;
  logic           frame_valid;
  logic           frame_ready;
  logic           overrun;

  always #5 clk = ~clk;

  ssg_to_bcd_capture #(.N_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .ssg         (ssg),
    .dig_sel     (dig_sel),
    .frame_bcd   (frame_bcd),
    .frame_err   (frame_err),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overrun     (overrun)
  );

  int total = 0;
  int bad   = 0;

  logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                           7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  // reference model state
  logic [4*N-1:0] m_bcd;
  logic [N-1:0]   m_err;
  logic [N-1:0]   m_seen;
  logic [N+6:0]   cur_val;
  int             cur_len;
  bit             cur_cap;
  logic [5*N-1:0] exp_q [$];
  logic [5*N-1:0] rx_q  [$];

  // frame receiver: records each newly loaded frame
  logic fv_q = 1'b0;
  logic rdy_q = 1'b0;
  always @(negedge clk) begin
    if (frame_valid && (!fv_q || rdy_q)) rx_q.push_back({frame_err, frame_bcd});
    fv_q  <= rst ? 1'b0 : frame_valid;
    rdy_q <= frame_ready;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic decode(input logic [6:0] p, output logic [3:0] b, output logic e);
    b = 4'hF;
    e = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (pat[k] === p) begin
        b = k[3:0];
        e = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    m_bcd   = '0;
    m_err   = '0;
    m_seen  = '0;
    cur_val = '0;
    cur_len = 0;
    cur_cap = 1'b1;
  endtask

  // Present one pattern on the bus for len cycles and update the model:
  // a dwell of at least S cycles on a single digit is captured once.
  task automatic dwell(input logic [N-1:0] sel, input logic [6:0] seg, input int len);
    logic [3:0] b;
    logic       e;
    int         idx;
`ifdef SSG_ACTIVE_LOW_EN
    dig_sel = ~sel;
    ssg     = ~seg;
`else
    dig_sel = sel;
    ssg     = seg;
`endif
    if ({sel, seg} === cur_val) begin
      cur_len += len;
    end else begin
      cur_val = {sel, seg};
      cur_len = len;
      cur_cap = 1'b0;
    end
    if ($countones(sel) == 1 && !cur_cap && cur_len >= S) begin
      cur_cap = 1'b1;
      idx = 0;
      for (int k = 0; k < N; k++) if (sel[k]) idx = k;
      decode(seg, b, e);
      m_bcd[4*idx +: 4] = b;
      m_err[idx]        = e;
      m_seen[idx]       = 1'b1;
      if (&m_seen) begin
        exp_q.push_back({m_err, m_bcd});
        m_seen = '0;
      end
    end
    repeat (len) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic flush();
    dwell('0, 7'b0000000, S + 3);
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) chk(tag, 64'(rx_q[i]), 64'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [N-1:0] rs;
    logic [6:0]   rp;
    int           r;

    rst         = 1'b1;
    ssg         = '0;
    dig_sel     = '0;
    frame_ready = 1'b1;
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("rst_valid", 64'(frame_valid), 64'd0);
    chk("rst_bcd", 64'(frame_bcd), 64'd0);
    chk("rst_err", 64'(frame_err), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    rst = 1'b0;

    // legal frame 9012
    dwell(4'b0001, 7'b1101101, 8);
    dwell(4'b0010, 7'b0110000, 8);
    dwell(4'b0100, 7'b1111110, 8);
    dwell(4'b1000, 7'b1111011, 8);
    flush();
    chk("t1_frame", (rx_q.size() > 0) ? 64'(rx_q[0]) : 'x, {44'd0, 4'b0000, 16'h9012});
    chk("t1_valid_drop", 64'(frame_valid), 64'd0);
    check_frames("t1");

    // illegal "E" on digit 2
    dwell(4'b0001, 7'b1101101, 8);
    dwell(4'b0010, 7'b0110000, 8);
    dwell(4'b0100, 7'b1001111, 8);
    dwell(4'b1000, 7'b1111011, 8);
    flush();
    chk("t2_frame", (rx_q.size() > 0) ? 64'(rx_q[0]) : 'x, {44'd0, 4'b0100, 16'h9F12});
    check_frames("t2");

    // digit 1 held one cycle short of the stability window
    dwell(4'b0001, pat[3], 8);
    dwell(4'b0010, pat[4], S - 1);
    dwell(4'b0100, pat[5], 8);
    dwell(4'b1000, pat[6], 8);
    flush();
    chk("t3_short_none", 64'(rx_q.size()), 64'd0);
    dwell(4'b0010, pat[4], S);
    flush();
    chk("t3_frame", (rx_q.size() > 0) ? 64'(rx_q[0]) : 'x, {44'd0, 4'b0000, 16'h6543});
    check_frames("t3");

    // two selects at once: ignored, partial frame survives
    dwell(4'b0001, pat[7], 8);
    dwell(4'b0010, pat[8], 8);
    dwell(4'b0100, pat[9], 8);
    dwell(4'b0011, pat[1], 10);
    chk("t4_multi_none", 64'(rx_q.size()), 64'd0);
    dwell(4'b1000, pat[2], 8);
    flush();
    chk("t4_frame", (rx_q.size() > 0) ? 64'(rx_q[0]) : 'x, {44'd0, 4'b0000, 16'h2987});
    check_frames("t4");

    // overrun: second frame completes while the first is still held
    frame_ready = 1'b0;
    dwell(4'b0001, pat[3], 8);
    dwell(4'b0010, pat[4], 8);
    dwell(4'b0100, pat[5], 8);
    dwell(4'b1000, pat[6], 8);
    flush();
    dwell(4'b0001, pat[7], 8);
    dwell(4'b0010, pat[8], 8);
    dwell(4'b0100, pat[9], 8);
    dwell(4'b1000, pat[0], 8);
    flush();
    chk("t5_valid_held", 64'(frame_valid), 64'd1);
    chk("t5_overrun", 64'(overrun), 64'd1);
    chk("t5_outputs", 64'({frame_err, frame_bcd}), {44'd0, 4'b0000, 16'h6543});
    void'(exp_q.pop_back());
    check_frames("t5");
    frame_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_valid_drop", 64'(frame_valid), 64'd0);
    @(posedge clk);
    #1;

    // reset with three of four digits captured
    dwell(4'b0001, pat[1], 8);
    dwell(4'b0010, pat[1], 8);
    dwell(4'b0100, pat[1], 8);
    flush();
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    model_reset();
    chk("t6_overrun_clr", 64'(overrun), 64'd0);
    chk("t6_valid_clr", 64'(frame_valid), 64'd0);
    dwell(4'b0001, pat[8], 8);
    dwell(4'b0010, pat[7], 8);
    dwell(4'b0100, pat[6], 8);
    dwell(4'b1000, pat[5], 8);
    flush();
    chk("t6_frame", (rx_q.size() > 0) ? 64'(rx_q[0]) : 'x, {44'd0, 4'b0000, 16'h5678});
    chk("t6_overrun", 64'(overrun), 64'd0);
    check_frames("t6");

    // randomized dwells against the model
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 9);
      if (r < 8) begin
        rs = '0;
        rs[$urandom_range(0, N - 1)] = 1'b1;
      end else begin
        rs = N'($urandom);
      end
      r = $urandom_range(0, 9);
      if (r < 8) rp = pat[$urandom_range(0, 9)];
      else       rp = 7'($urandom);
      dwell(rs, rp, $urandom_range(1, 8));
    end
    flush();
    check_frames("rand");
    chk("rand_overrun", 64'(overrun), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
